// File: rtl/div_reconstruct_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_reconstruct_checker_pkg
// Purpose  : Shared types and default constants for the divider
//            reconstruction checker (FSM state encoding, default widths,
//            saturation all-ones values).
// Revision : 1.0 - initial release
// ============================================================================
package div_reconstruct_checker_pkg;

  localparam int DEF_W     = 8;          // divisor/quotient/remainder width
  localparam int DEF_W2    = 2 * DEF_W;  // dividend/product width
  localparam int DEF_ACC_W = 24;         // absolute-error accumulator width
  localparam int DEF_CNT_W = 16;         // sample counter width

  localparam logic [DEF_ACC_W-1:0] DEF_ACC_ONES = {DEF_ACC_W{1'b1}};
  localparam logic [DEF_CNT_W-1:0] DEF_CNT_ONES = {DEF_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : div_reconstruct_checker_pkg
`default_nettype wire

// File: rtl/div_reconstruct_checker_err_stats.sv
`default_nettype none
// ============================================================================
// Module   : div_err_stats
// Purpose  : Error statistics for the reconstruction checker. Takes the
//            signed error of each accepted sample, accumulates |err| with
//            saturation and counts samples with saturation. A clear request
//            takes priority over a coincident sample.
// Ports    : clk, rst           - clock, async active-high reset
//            sample_i           - one accepted result this cycle
//            err_i   [W2:0]     - signed n_ref - prod of that result
//            clr_i              - synchronous statistics clear
//            acc_abs_err_o      - saturating sum of |err|
//            sample_cnt_o       - saturating sample count
// Revision : 1.0 - initial release
// ============================================================================
module div_err_stats
  import div_reconstruct_checker_pkg::*;
#(
  parameter int W2    = DEF_W2,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_i,
  input  logic [W2:0]      err_i,
  input  logic             clr_i,
  output logic [ACC_W-1:0] acc_abs_err_o,
  output logic [CNT_W-1:0] sample_cnt_o
);

  // One spare bit above the wider operand so the sum cannot wrap before the
  // saturation compare.
  localparam int SUM_W = ((ACC_W > W2) ? ACC_W : W2) + 1;
  localparam logic [ACC_W-1:0] ACC_ONES = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2:0]      neg_w;
  logic [W2-1:0]    abs_w;
  logic [SUM_W-1:0] sum_w;

  // Magnitude always fits in W2 bits: the most negative error is
  // -(2^W2 - 1), never -2^W2.
  assign neg_w = -err_i;
  assign abs_w = err_i[W2] ? neg_w[W2-1:0] : err_i[W2-1:0];
  assign sum_w = SUM_W'(acc_q) + SUM_W'(abs_w);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_i) begin
      acc_d = (sum_w > SUM_W'(ACC_ONES)) ? ACC_ONES : sum_w[ACC_W-1:0];
      cnt_d = (cnt_q == CNT_ONES) ? CNT_ONES : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_abs_err_o = acc_q;
  assign sample_cnt_o  = cnt_q;

endmodule : div_err_stats
`default_nettype wire

// File: rtl/div_reconstruct_checker.sv
`default_nettype none
// ============================================================================
// Module   : div_reconstruct_checker
// Purpose  : Rebuilds a divider's dividend as prod = q*d + r by shift-add,
//            one quotient bit per cycle, compares it with the true dividend
//            and accumulates |n_ref - prod| statistics.
// Ports    : clk, rst                 - clock, async active-high reset
//            in_valid_i / in_ready_o  - operand handshake
//            q_i, d_i, r_i [W]        - quotient, divisor, remainder
//            n_ref_i [2W]             - true dividend
//            out_valid_o / out_ready_i- result handshake
//            prod_o [2W]              - q*d + r
//            err_o [2W+1]             - signed n_ref - prod
//            acc_abs_err_o [ACC_W]    - saturating sum of |err|
//            sample_cnt_o [CNT_W]     - saturating completed-sample count
//            stat_clr_i               - synchronous statistics clear
// Revision : 1.0 - initial release
// ============================================================================
module div_reconstruct_checker
  import div_reconstruct_checker_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     q_i,
  input  logic [W-1:0]     d_i,
  input  logic [W-1:0]     r_i,
  input  logic [2*W-1:0]   n_ref_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2*W-1:0]   prod_o,
  output logic [2*W:0]     err_o,
  output logic [ACC_W-1:0] acc_abs_err_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  input  logic             stat_clr_i
);

  localparam int W2    = 2 * W;
  localparam int IDX_W = $clog2(W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W);

  state_e          state_q;
  logic [W-1:0]    q_sh_q;    // quotient, shifted right so bit 0 is current
  logic [W2-1:0]   d_sh_q;    // divisor, shifted left to current weight
  logic [W2-1:0]   n_ref_q;
  logic [W2-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0] idx_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W2-1:0]   prod_q;
  logic [W2:0]     err_q, err_d;
  logic            out_hs_w;

  // Shift-add step: add the weighted divisor when the current quotient bit
  // is set. Max q*d + r = 2^W2 - 2^W, so the W2-bit add never overflows.
  always_comb begin
    acc_d = acc_q;
    if (q_sh_q[0]) begin
      acc_d = acc_q + d_sh_q;
    end
  end

  assign err_d = {1'b0, n_ref_q} - {1'b0, acc_q};

  // W add cycles (idx 0..W-1), then one cycle with idx == W in which the
  // final accumulator is registered into prod/err; this fixes the
  // accept-to-valid latency at W+1 edges regardless of operand values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      q_sh_q      <= '0;
      d_sh_q      <= '0;
      n_ref_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      err_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            q_sh_q     <= q_i;
            d_sh_q     <= {{W{1'b0}}, d_i};
            acc_q      <= {{W{1'b0}}, r_i};
            n_ref_q    <= n_ref_i;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (idx_q == LAST_IDX) begin
            prod_q      <= acc_q;
            err_q       <= err_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q  <= acc_d;
            q_sh_q <= q_sh_q >> 1;
            d_sh_q <= d_sh_q << 1;
            idx_q  <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_hs_w = out_valid_q & out_ready_i;

  div_err_stats #(
    .W2    (W2),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_stats (
    .clk           (clk),
    .rst           (rst),
    .sample_i      (out_hs_w),
    .err_i         (err_q),
    .clr_i         (stat_clr_i),
    .acc_abs_err_o (acc_abs_err_o),
    .sample_cnt_o  (sample_cnt_o)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign prod_o      = prod_q;
  assign err_o       = err_q;

endmodule : div_reconstruct_checker
`default_nettype wire

// File: tb/tb_div_reconstruct_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_reconstruct_checker
// Purpose  : Self-checking bench for div_reconstruct_checker. A behavioural
//            model (plain arithmetic q*d+r, n_ref-prod, saturating sums and
//            a latency countdown) is compared against the DUT every cycle;
//            directed tests pin literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_reconstruct_checker;

  localparam int  W        = 8;
  localparam int  ACC_W    = 24;
  localparam int  CNT_W    = 16;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [W-1:0]     q_i, d_i, r_i;
  logic [2*W-1:0]   n_ref_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [2*W-1:0]   prod_o;
  logic [2*W:0]     err_o;
  logic [ACC_W-1:0] acc_abs_err_o;
  logic [CNT_W-1:0] sample_cnt_o;
  logic             stat_clr_i;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  div_reconstruct_checker #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .q_i           (q_i),
    .d_i           (d_i),
    .r_i           (r_i),
    .n_ref_i       (n_ref_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .prod_o        (prod_o),
    .err_o         (err_o),
    .acc_abs_err_o (acc_abs_err_o),
    .sample_cnt_o  (sample_cnt_o),
    .stat_clr_i    (stat_clr_i)
  );

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ------------------------------------------------------------------
  // Behavioural model: result = q*d + r, error = n_ref - result, visible
  // W+1 edges after acceptance; statistics are saturating sums.
  // ------------------------------------------------------------------
  bit     m_idle, m_rdy, m_valid;
  int     m_cd;
  longint m_prod, m_err, p_prod, p_err, m_acc, m_cnt;

  always @(posedge clk) begin
    bit hs_in, hs_out;
    longint a;
    if (rst) begin
      m_idle = 1; m_rdy = 0; m_valid = 0; m_cd = 0;
      m_prod = 0; m_err = 0; p_prod = 0; p_err = 0; m_acc = 0; m_cnt = 0;
    end else begin
      hs_in  = in_valid_i && m_rdy;
      hs_out = m_valid && out_ready_i;
      if (stat_clr_i) begin
        m_acc = 0; m_cnt = 0;
      end else if (hs_out) begin
        a     = (m_err < 0) ? -m_err : m_err;
        m_acc = (m_acc + a > ACC_MAX) ? ACC_MAX : m_acc + a;
        m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
      if (hs_out) begin
        m_valid = 0; m_idle = 1;
      end
      if (hs_in) begin
        m_idle = 0;
        m_cd   = W + 1;
        p_prod = longint'(q_i) * longint'(d_i) + longint'(r_i);
        p_err  = longint'(n_ref_i) - p_prod;
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          m_valid = 1; m_prod = p_prod; m_err = p_err;
        end
      end
      m_rdy = m_idle;
    end
    #1;
    chk("in_ready",    longint'(in_ready_o),    longint'(m_rdy));
    chk("out_valid",   longint'(out_valid_o),   longint'(m_valid));
    chk("prod",        longint'(prod_o),        m_prod);
    chk("err",         longint'($signed(err_o)), m_err);
    chk("acc_abs_err", longint'(acc_abs_err_o), m_acc);
    chk("sample_cnt",  longint'(sample_cnt_o),  m_cnt);
  end

  // ------------------------------------------------------------------
  // Stimulus helpers (all driving at negedge)
  // ------------------------------------------------------------------
  longint obs_prod, obs_err;
  int     obs_lat;

  task automatic do_sample(input logic [W-1:0] q, input logic [W-1:0] d,
                           input logic [W-1:0] r, input logic [2*W-1:0] n,
                           input int hold, input bit clr);
    int t;
    t = 0;
    while (!in_ready_o && t < 50) begin @(negedge clk); t++; end
    if (!in_ready_o) chk("in_ready_timeout", 0, 1);
    in_valid_i = 1'b1; q_i = q; d_i = d; r_i = r; n_ref_i = n;
    @(negedge clk);
    // Scramble operands after acceptance to prove they were latched.
    in_valid_i = 1'b0;
    q_i = W'($urandom); d_i = W'($urandom); r_i = W'($urandom);
    n_ref_i = (2*W)'($urandom);
    t = 0;
    while (!out_valid_o && t < 50) begin @(negedge clk); t++; end
    if (!out_valid_o) chk("out_valid_timeout", 0, 1);
    obs_lat  = t;
    obs_prod = longint'(prod_o);
    obs_err  = longint'($signed(err_o));
    repeat (hold) @(negedge clk);
    out_ready_i = 1'b1; stat_clr_i = clr;
    @(negedge clk);
    out_ready_i = 1'b0; stat_clr_i = 1'b0;
  endtask

  task automatic pulse_clr();
    stat_clr_i = 1'b1;
    @(negedge clk);
    stat_clr_i = 1'b0;
  endtask

  // ------------------------------------------------------------------
  // Directed and randomized sequences
  // ------------------------------------------------------------------
  initial begin
    longint acc0;
    int     t;
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; stat_clr_i = 1'b0;
    q_i = '0; d_i = '0; r_i = '0; n_ref_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_in_ready_after_reset", longint'(in_ready_o), 1);

    // 1: reset pulse mid-sequence, then a clean sample
    in_valid_i = 1'b1; q_i = 8'd9; d_i = 8'd9; r_i = 8'd1; n_ref_i = 16'd82;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_sample(8'd5, 8'd10, 8'd3, 16'd53, 0, 1'b0);
    chk("lit_t1_latency", obs_lat, 9);
    chk("lit_t1_prod", obs_prod, 53);
    chk("lit_t1_err", obs_err, 0);
    chk("lit_t1_acc", longint'(acc_abs_err_o), 0);
    chk("lit_t1_cnt", longint'(sample_cnt_o), 1);

    // 2: maximum product, then a positive error
    pulse_clr();
    do_sample(8'd255, 8'd255, 8'd255, 16'd65280, 0, 1'b0);
    chk("lit_t2a_prod", obs_prod, 16'hFF00);
    chk("lit_t2a_err", obs_err, 0);
    do_sample(8'd0, 8'd7, 8'd0, 16'd20, 0, 1'b0);
    chk("lit_t2b_prod", obs_prod, 0);
    chk("lit_t2b_err", obs_err, 20);
    chk("lit_t2b_acc", longint'(acc_abs_err_o), 20);
    chk("lit_t2b_cnt", longint'(sample_cnt_o), 2);

    // 3: backpressure for 5 cycles
    do_sample(8'd3, 8'd4, 8'd1, 16'd13, 5, 1'b0);
    chk("lit_t3_prod", obs_prod, 13);
    chk("lit_t3_prod_held", longint'(prod_o), 13);
    chk("lit_t3_cnt", longint'(sample_cnt_o), 3);

    // 4: zero divisor
    do_sample(8'd255, 8'd0, 8'h2A, 16'h002A, 0, 1'b0);
    chk("lit_t4a_prod", obs_prod, 42);
    chk("lit_t4a_err", obs_err, 0);
    acc0 = longint'(acc_abs_err_o);
    do_sample(8'd255, 8'd0, 8'h2A, 16'h0000, 0, 1'b0);
    chk("lit_t4b_err", obs_err, -42);
    chk("lit_t4b_acc", longint'(acc_abs_err_o), acc0 + 42);

    // 5: reset during BUSY cycle 4
    in_valid_i = 1'b1; q_i = 8'd17; d_i = 8'd3; r_i = 8'd2; n_ref_i = 16'd53;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("lit_t5_valid_in_rst", longint'(out_valid_o), 0);
    chk("lit_t5_acc_in_rst", longint'(acc_abs_err_o), 0);
    rst = 1'b0;
    t = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_o) t++;
    end
    chk("lit_t5_no_valid", t, 0);
    chk("lit_t5_in_ready", longint'(in_ready_o), 1);
    do_sample(8'd17, 8'd3, 8'd2, 16'd53, 1, 1'b0);
    chk("lit_t5_prod", obs_prod, 53);

    // 6: clear wins over a coincident handshake, then saturation
    do_sample(8'd1, 8'd1, 8'd8, 16'd2, 0, 1'b1);
    chk("lit_t6_err", obs_err, -7);
    chk("lit_t6_acc_clr", longint'(acc_abs_err_o), 0);
    chk("lit_t6_cnt_clr", longint'(sample_cnt_o), 0);
    // 256 * 65535 = 2^24 - 256; +252 leaves all-ones minus 3
    for (int i = 0; i < 256; i++) do_sample(8'd0, 8'd0, 8'd0, 16'hFFFF, 0, 1'b0);
    do_sample(8'd0, 8'd0, 8'd0, 16'd252, 0, 1'b0);
    chk("lit_t6_acc_near", longint'(acc_abs_err_o), ACC_MAX - 3);
    do_sample(8'd0, 8'd0, 8'd10, 16'd0, 0, 1'b0);
    chk("lit_t6_acc_sat", longint'(acc_abs_err_o), ACC_MAX);
    pulse_clr();

    // Randomized samples against the model
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0]   rq, rd, rr;
      logic [2*W-1:0] rn;
      rq = W'($urandom); rd = W'($urandom); rr = W'($urandom);
      rn = ($urandom_range(0, 1) == 0) ? (2*W)'(rq * rd + rr) : (2*W)'($urandom);
      do_sample(rq, rd, rr, rn, $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_div_reconstruct_checker
`default_nettype wire
